// File: rtl/multicycle_controller.sv
// Multicycle fetch/decode/execute/memory/writeback controller with bounded memory waits,
// sticky trap and retired-instruction counter. Define PHILV_BRANCH_EN to enable BRANCH/JAL.
module multicycle_controller #(
    parameter int unsigned OPCODE_WIDTH    = 7,
    parameter int unsigned ALU_SRC_B_WIDTH = 2,
    parameter int unsigned MEM_TIMEOUT     = 15,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [OPCODE_WIDTH-1:0]    opCode,
    input  logic                       iMemReady,
    input  logic                       dMemReady,
    input  logic                       branchTaken,
    output logic                       PCWrite,
    output logic                       IRWrite,
    output logic                       DMemRead,
    output logic                       DMemWrite,
    output logic                       ALUOverride,
    output logic                       regFileWrite,
    output logic                       ALUSrcA,
    output logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB,
    output logic [1:0]                 regFileWriteSrc,
    output logic                       PCSrc,
    output logic                       trap,
    output logic [COUNT_WIDTH-1:0]     instrCount
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPCODE_WIDTH-1:0] OpAluReg = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OpAluImm = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OpLoad   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OpStore  = OPCODE_WIDTH'(7'b0100011);
`ifdef PHILV_BRANCH_EN
    localparam logic [OPCODE_WIDTH-1:0] OpBranch = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OpJal    = OPCODE_WIDTH'(7'b1101111);
`endif

    localparam logic [ALU_SRC_B_WIDTH-1:0] SrcBReg    = ALU_SRC_B_WIDTH'(0);
    localparam logic [ALU_SRC_B_WIDTH-1:0] SrcBImm    = ALU_SRC_B_WIDTH'(1);
    localparam logic [ALU_SRC_B_WIDTH-1:0] SrcBConst4 = ALU_SRC_B_WIDTH'(2);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StMemLoad  = 4'd4,
        StMemStore = 4'd5,
        StWb       = 4'd6,
        StWbMem    = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StTrap     = 4'd10
    } state_e;

    state_e                 state_q, state_d;
    logic [WaitW-1:0]       wait_q, wait_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   in_wait;
    logic                   mem_ready;

`ifndef PHILV_BRANCH_EN
    logic unused_branch_taken;
    assign unused_branch_taken = branchTaken;
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        count_d   = count_q;
        in_wait   = 1'b0;
        mem_ready = 1'b0;
        case (state_q)
            StFetch: begin
                in_wait   = 1'b1;
                mem_ready = iMemReady;
                if (iMemReady) state_d = StDecode;
            end
            StDecode: begin
                case (opCode)
                    OpAluReg:                  state_d = StExecR;
                    OpAluImm, OpLoad, OpStore: state_d = StExecI;
`ifdef PHILV_BRANCH_EN
                    OpBranch:                  state_d = StBranch;
                    OpJal:                     state_d = StJump;
`endif
                    default:                   state_d = StTrap;
                endcase
            end
            StExecR: state_d = StWb;
            StExecI: begin
                if (opCode == OpLoad)       state_d = StMemLoad;
                else if (opCode == OpStore) state_d = StMemStore;
                else                        state_d = StWb;
            end
            StMemLoad: begin
                in_wait   = 1'b1;
                mem_ready = dMemReady;
                if (dMemReady) state_d = StWbMem;
            end
            StMemStore: begin
                in_wait   = 1'b1;
                mem_ready = dMemReady;
                if (dMemReady) state_d = StFetch;
            end
            StWb, StWbMem: state_d = StFetch;
`ifdef PHILV_BRANCH_EN
            StBranch, StJump: state_d = StFetch;
`endif
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Ready on the timeout cycle itself is taken above and never reaches this branch.
        if (in_wait && !mem_ready) begin
            if (wait_q == WaitW'(MEM_TIMEOUT)) state_d = StTrap;
            else                              wait_d  = wait_q + 1'b1;
        end

        if (state_d == StFetch &&
            state_q inside {StWb, StWbMem, StMemStore, StBranch, StJump}) begin
            count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        PCWrite         = 1'b0;
        IRWrite         = 1'b0;
        DMemRead        = 1'b0;
        DMemWrite       = 1'b0;
        ALUOverride     = 1'b0;
        regFileWrite    = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = SrcBReg;
        regFileWriteSrc = 2'd0;
        PCSrc           = 1'b0;
        trap            = 1'b0;
        case (state_q)
            StFetch: begin
                ALUOverride = 1'b1;
                ALUSrcB     = SrcBConst4;
                IRWrite     = iMemReady;
            end
            StDecode: PCWrite = 1'b1;
            StExecR:  ALUSrcA = 1'b1;
            StExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StMemLoad:  DMemRead  = 1'b1;
            StMemStore: DMemWrite = 1'b1;
            StWb:       regFileWrite = 1'b1;
            StWbMem: begin
                regFileWrite    = 1'b1;
                regFileWriteSrc = 2'd1;
            end
`ifdef PHILV_BRANCH_EN
            StBranch: begin
                ALUSrcA = 1'b1;
                PCSrc   = 1'b1;
                PCWrite = branchTaken;
            end
            StJump: begin
                PCWrite         = 1'b1;
                PCSrc           = 1'b1;
                regFileWrite    = 1'b1;
                regFileWriteSrc = 2'd2;
            end
`endif
            StTrap:  trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    assign instrCount = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle output trace built from instruction-level rules.
module tb_multicycle_controller;

    localparam int MT = 15;
    localparam int KR = 0, KI = 1, KLD = 2, KST = 3, KBR = 4, KJAL = 5, KILL = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opCode;
    logic        iMemReady, dMemReady, branchTaken;
    logic        PCWrite, IRWrite, DMemRead, DMemWrite, ALUOverride, regFileWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, regFileWriteSrc;
    logic        PCSrc, trap;
    logic [31:0] instrCount;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_cnt = '0;
    logic [12:0] obs;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .iMemReady(iMemReady),
        .dMemReady(dMemReady), .branchTaken(branchTaken), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .DMemRead(DMemRead), .DMemWrite(DMemWrite),
        .ALUOverride(ALUOverride), .regFileWrite(regFileWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .regFileWriteSrc(regFileWriteSrc), .PCSrc(PCSrc), .trap(trap),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, IRWrite, DMemRead, DMemWrite, ALUOverride, regFileWrite, ALUSrcA,
                  ALUSrcB, regFileWriteSrc, PCSrc, trap};

    function automatic logic [12:0] ov(input logic pcw, input logic irw, input logic dr,
                                       input logic dw, input logic ovr, input logic rfw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ws, input logic ps, input logic tp);
        return {pcw, irw, dr, dw, ovr, rfw, sa, sb, ws, ps, tp};
    endfunction

    function automatic logic [12:0] o_fetch(input logic irw);
        return ov(0, irw, 0, 0, 1, 0, 0, 2'd2, 2'd0, 0, 0);
    endfunction
    function automatic logic [12:0] o_decode();  return ov(1,0,0,0,0,0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_exec_r();  return ov(0,0,0,0,0,0,1,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_exec_i();  return ov(0,0,0,0,0,0,1,2'd1,2'd0,0,0); endfunction
    function automatic logic [12:0] o_load();    return ov(0,0,1,0,0,0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_store();   return ov(0,0,0,1,0,0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_wb();      return ov(0,0,0,0,0,1,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_wb_mem();  return ov(0,0,0,0,0,1,0,2'd0,2'd1,0,0); endfunction
    function automatic logic [12:0] o_jump();    return ov(1,0,0,0,0,1,0,2'd0,2'd2,1,0); endfunction
    function automatic logic [12:0] o_trap();    return ov(0,0,0,0,0,0,0,2'd0,2'd0,0,1); endfunction
    function automatic logic [12:0] o_branch(input logic bt);
        return ov(bt, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 1, 0);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] opc(input int k);
        logic [6:0] v;
        case (k)
            KR:      v = 7'b0110011;
            KI:      v = 7'b0010011;
            KLD:     v = 7'b0000011;
            KST:     v = 7'b0100011;
            KBR:     v = 7'b1100011;
            KJAL:    v = 7'b1101111;
            default: begin
                v = 7'($urandom);
                if (v inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111}) v = 7'b0000000;
            end
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic imr, input logic dmr, input logic bt,
                       input logic [12:0] exp, input string tag);
        iMemReady   = imr;
        dMemReady   = dmr;
        branchTaken = bt;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        iMemReady = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk({tag, "_async_out"}, 32'(obs), 32'(o_fetch(1'b1)));
        chk({tag, "_async_cnt"}, instrCount, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_held_out"}, 32'(obs), 32'(o_fetch(1'b1)));
        rst_n     = 1'b1;
        model_cnt = '0;
    endtask

    task automatic trap_and_reset(input string tag);
        for (int i = 0; i < 3; i++) cyc(rb(), rb(), rb(), o_trap(), {tag, "_trap"});
        do_reset({tag, "_rst"});
    endtask

    // which: 0 fetch, 1 load, 2 store; lows above MT means the access never completes
    task automatic wait_phase(input int which, input int lows, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < lows && i <= MT; i++) begin
            case (which)
                0:       cyc(1'b0, rb(), rb(), o_fetch(1'b0), "fetch_wait");
                1:       cyc(rb(), 1'b0, rb(), o_load(), "load_wait");
                default: cyc(rb(), 1'b0, rb(), o_store(), "store_wait");
            endcase
        end
        if (lows > MT) begin
            trapped = 1'b1;
        end else begin
            case (which)
                0:       cyc(1'b1, rb(), rb(), o_fetch(1'b1), "fetch_accept");
                1:       cyc(rb(), 1'b1, rb(), o_load(), "load_accept");
                default: cyc(rb(), 1'b1, rb(), o_store(), "store_accept");
            endcase
        end
    endtask

    task automatic run_instr(input int k, input int fw, input int mw, input logic bt);
        bit tr;
        opCode = opc(k);
        wait_phase(0, fw, tr);
        if (tr) begin trap_and_reset("fetch_timeout"); return; end
        cyc(rb(), rb(), rb(), o_decode(), "decode");
        case (k)
            KR: begin
                cyc(rb(), rb(), rb(), o_exec_r(), "exec_r");
                cyc(rb(), rb(), rb(), o_wb(), "wb");
            end
            KI: begin
                cyc(rb(), rb(), rb(), o_exec_i(), "exec_i");
                cyc(rb(), rb(), rb(), o_wb(), "wb");
            end
            KLD: begin
                cyc(rb(), rb(), rb(), o_exec_i(), "exec_i_ld");
                wait_phase(1, mw, tr);
                if (tr) begin trap_and_reset("load_timeout"); return; end
                cyc(rb(), rb(), rb(), o_wb_mem(), "wb_mem");
            end
            KST: begin
                cyc(rb(), rb(), rb(), o_exec_i(), "exec_i_st");
                wait_phase(2, mw, tr);
                if (tr) begin trap_and_reset("store_timeout"); return; end
            end
`ifdef PHILV_BRANCH_EN
            KBR:  cyc(rb(), rb(), bt, o_branch(bt), "branch");
            KJAL: cyc(rb(), rb(), rb(), o_jump(), "jump");
`else
            KBR:  begin trap_and_reset("branch_off"); return; end
            KJAL: begin trap_and_reset("jal_off"); return; end
`endif
            default: begin trap_and_reset("illegal"); return; end
        endcase
        model_cnt = model_cnt + 1;
        chk("instr_count", instrCount, model_cnt);
        chk("back_in_fetch", 32'(ALUOverride), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        opCode      = '0;
        iMemReady   = 1'b0;
        dMemReady   = 1'b0;
        branchTaken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(obs), 32'(o_fetch(1'b0)));
        chk("reset_cnt", instrCount, 32'd0);
        rst_n = 1'b1;

        run_instr(KR, 0, 0, 1'b0);
        run_instr(KLD, 0, 3, 1'b0);
        run_instr(KST, 0, 0, 1'b0);
        run_instr(KBR, 0, 0, 1'b1);
        run_instr(KBR, 0, 0, 1'b0);
        run_instr(KJAL, 0, 0, 1'b0);
        run_instr(KI, MT, 0, 1'b0);
        run_instr(KLD, 2, MT, 1'b0);
        run_instr(KST, 0, MT, 1'b0);
        run_instr(KR, MT + 1, 0, 1'b0);
        run_instr(KR, 0, 0, 1'b0);
        run_instr(KLD, 0, MT + 1, 1'b0);
        run_instr(KST, 1, MT + 1, 1'b0);
        opCode = 7'b0000000;
        run_instr(KILL, 0, 0, 1'b0);

        // Reset while EXEC_R is active must abort before any writeback
        run_instr(KI, 0, 0, 1'b0);
        opCode = opc(KR);
        cyc(1'b1, 1'b0, 1'b0, o_fetch(1'b1), "pre_abort_fetch");
        cyc(1'b0, 1'b0, 1'b0, o_decode(), "pre_abort_decode");
        #1;
        chk("pre_abort_exec_r", 32'(obs), 32'(o_exec_r()));
        do_reset("mid_exec");
        run_instr(KR, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int k, fw, mw;
            k  = ($urandom_range(0, 19) == 0) ? KILL : int'($urandom_range(0, 5));
            fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, MT + 1));
            mw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, MT + 1));
            if (fw == MT + 1 && $urandom_range(0, 2) != 0) fw = MT;
            if (mw == MT + 1 && $urandom_range(0, 2) != 0) mw = MT;
            run_instr(k, fw, mw, rb());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
